// File: rtl/mips_pkg.sv
// mips_pkg: shared datapath constants and types for the write-back slice.
//   DATA_W   - datapath width
//   ADDR_W   - register address width
//   NUM_REGS - register file depth (2**ADDR_W)
//   CNT_W    - scoreboard in-flight counter width per register
package mips_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam int unsigned CNT_W    = 2;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [CNT_W-1:0]  sb_cnt_t;

endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register count of in-flight writers, used by ID for RAW
// hazard detection.
//   clk, rst          - clock, asynchronous active-high reset
//   inc_i/inc_dest_i  - an issued instruction will write inc_dest_i (never r0)
//   dec_i/dec_dest_i  - a write to dec_dest_i retires this cycle (never r0)
//   src1_i, src2_i    - registers queried by ID
//   hz1_o, hz2_o      - RAW hazard flags for src1_i/src2_i (combinational)
//   sb_err_o          - sticky overflow/underflow flag (only with WB_SB_ERR_EN)
// Counters saturate at max and floor at zero. Macro: WB_SB_ERR_EN.
module wb_scoreboard
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W,
  parameter int unsigned CNT_W  = mips_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] inc_dest_i,
  input  logic              dec_i,
  input  logic [ADDR_W-1:0] dec_dest_i,
  input  logic [ADDR_W-1:0] src1_i,
  input  logic [ADDR_W-1:0] src2_i,
  output logic              hz1_o,
  output logic              hz2_o
`ifdef WB_SB_ERR_EN
  ,
  output logic              sb_err_o
`endif
);

  localparam int unsigned      NREGS   = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];

  // Matching inc and dec on one register cancel; saturation/floor make
  // overflow and underflow no-ops on the count.
  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r != 0) begin
        if (inc_i && inc_dest_i == ADDR_W'(r) &&
            !(dec_i && dec_dest_i == ADDR_W'(r))) begin
          if (cnt_q[r] != CNT_MAX) cnt_d[r] = cnt_q[r] + CNT_ONE;
        end else if (dec_i && dec_dest_i == ADDR_W'(r) &&
                     !(inc_i && inc_dest_i == ADDR_W'(r))) begin
          if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - CNT_ONE;
        end
      end else begin
        cnt_d[r] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  // A write retiring this cycle lands in the register file at the negedge,
  // ahead of the ID/EX capture, so it no longer counts against its own
  // register. The subtraction floors at zero so an underflowing retire never
  // raises a spurious hazard.
  always_comb begin
    hz1_o = (src1_i != '0) && (cnt_q[src1_i] != '0) &&
            !(dec_i && dec_dest_i == src1_i && cnt_q[src1_i] == CNT_ONE);
    hz2_o = (src2_i != '0) && (cnt_q[src2_i] != '0) &&
            !(dec_i && dec_dest_i == src2_i && cnt_q[src2_i] == CNT_ONE);
  end

`ifdef WB_SB_ERR_EN
  logic ovf, udf;
  logic sb_err_q, sb_err_d;

  always_comb begin
    ovf      = inc_i && (cnt_q[inc_dest_i] == CNT_MAX) &&
               !(dec_i && dec_dest_i == inc_dest_i);
    udf      = dec_i && (cnt_q[dec_dest_i] == '0) &&
               !(inc_i && inc_dest_i == dec_dest_i);
    sb_err_d = sb_err_q | ovf | udf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb_err_q <= 1'b0;
    else     sb_err_q <= sb_err_d;
  end

  assign sb_err_o = sb_err_q;
`endif

endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back pipeline register in front of the register file.
// Registers MEM results, selects ALU result or load data, and drives the
// register-file write port; a scoreboard supplies RAW hazard flags to ID.
//   clk, rst                   - clock, asynchronous active-high reset
//   freeze                     - SRAM stall: capture a bubble this cycle
//   mem_valid/mem_wb_en/mem_r_en, mem_dest, mem_alu, mem_rdata - MEM results
//   iss_valid/iss_wb_en, iss_dest - instruction issued by ID this cycle
//   src1, src2                 - ID source registers under query
//   dest, Write_val, Write_En  - register-file write port (Write_En one pulse)
//   hz1, hz2                   - RAW hazard on src1/src2 (combinational)
//   sb_err                     - sticky scoreboard error (only with WB_SB_ERR_EN)
// Macro: WB_SB_ERR_EN adds the sb_err port.
module wb_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W,
  parameter int unsigned CNT_W  = mips_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              mem_valid,
  input  logic              mem_wb_en,
  input  logic              mem_r_en,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_alu,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              iss_valid,
  input  logic              iss_wb_en,
  input  logic [ADDR_W-1:0] iss_dest,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  output logic [ADDR_W-1:0] dest,
  output logic [DATA_W-1:0] Write_val,
  output logic              Write_En,
  output logic              hz1,
  output logic              hz2
`ifdef WB_SB_ERR_EN
  ,
  output logic              sb_err
`endif
);

  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] wval_q, wval_d;
  logic              wen_q,  wen_d;
  logic              sb_inc;

  // A frozen or empty cycle holds dest/value and drops the enable, so each
  // instruction pulses Write_En exactly once.
  always_comb begin
    dest_d = dest_q;
    wval_d = wval_q;
    wen_d  = 1'b0;
    if (!freeze && mem_valid) begin
      dest_d = mem_dest;
      wval_d = mem_r_en ? mem_rdata : mem_alu;
      wen_d  = mem_wb_en && (mem_dest != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest_q <= '0;
      wval_q <= '0;
      wen_q  <= 1'b0;
    end else begin
      dest_q <= dest_d;
      wval_q <= wval_d;
      wen_q  <= wen_d;
    end
  end

  assign sb_inc    = iss_valid && iss_wb_en && (iss_dest != '0);
  assign dest      = dest_q;
  assign Write_val = wval_q;
  assign Write_En  = wen_q;

  wb_scoreboard #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (sb_inc),
    .inc_dest_i (iss_dest),
    .dec_i      (wen_q),
    .dec_dest_i (dest_q),
    .src1_i     (src1),
    .src2_i     (src2),
    .hz1_o      (hz1),
    .hz2_o      (hz2)
`ifdef WB_SB_ERR_EN
    ,
    .sb_err_o   (sb_err)
`endif
  );

endmodule
